// File: rtl/disp_share_sched_if.sv
// Display-share bundle: source requests/data in, grant and
// seven-segment drive out.
interface disp_share_sched_if;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] gnt;
    logic [7:0] digit_seg;
    logic [1:0] digit_cath;

    modport master (
        output req, data0, data1,
        input  gnt, digit_seg, digit_cath
    );

    modport slave (
        input  req, data0, data1,
        output gnt, digit_seg, digit_cath
    );
endinterface

// File: rtl/disp_share_sched.sv
// Round-robin owner of the two-digit display with hold time,
// per-frame value latch and blanked digit multiplexing.
module disp_share_sched #(
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 16,
    parameter int HOLD_CYC  = 50000000
) (
    input logic           clk,
    input logic           rst,
    disp_share_sched_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_CYC + 1);

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          last, last_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic [SW-1:0] scan, scan_nxt;
    logic          slot, slot_nxt;
    logic [7:0]    frame, frame_nxt;
    logic [1:0]    gnt_nxt, cath_nxt;
    logic [7:0]    seg_nxt;
    logic [3:0]    nib;

    // Tie goes to whichever source did not own the display last.
    function automatic logic [1:0] pick(
        input logic [1:0] r,
        input logic       l
    );
        unique case (r)
            2'b01:   pick = OWN0;
            2'b10:   pick = OWN1;
            2'b11:   pick = l ? OWN0 : OWN1;
            default: pick = IDLE;
        endcase
    endfunction

    function automatic logic [7:0] hex(input logic [3:0] n);
        unique case (n)
            4'h0: hex = 8'hFC;
            4'h1: hex = 8'h60;
            4'h2: hex = 8'hDA;
            4'h3: hex = 8'hF2;
            4'h4: hex = 8'h66;
            4'h5: hex = 8'hB6;
            4'h6: hex = 8'hBE;
            4'h7: hex = 8'hE0;
            4'h8: hex = 8'hFE;
            4'h9: hex = 8'hF6;
            4'hA: hex = 8'hEE;
            4'hB: hex = 8'h3E;
            4'hC: hex = 8'h9C;
            4'hD: hex = 8'h7A;
            4'hE: hex = 8'h9E;
            default: hex = 8'h8E;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        unique case (state)
            OWN0: begin
                if (!bus.req[0])
                    state_nxt = pick(bus.req, last);
                else if (hold >= HOLD_LAST && bus.req[1])
                    state_nxt = OWN1;
            end
            OWN1: begin
                if (!bus.req[1])
                    state_nxt = pick(bus.req, last);
                else if (hold >= HOLD_LAST && bus.req[0])
                    state_nxt = OWN0;
            end
            default: state_nxt = pick(bus.req, last);
        endcase
    end

    always_comb begin
        last_nxt  = last;
        hold_nxt  = hold;
        scan_nxt  = scan;
        slot_nxt  = slot;
        frame_nxt = frame;
        if (state_nxt != state) begin
            if (state_nxt != IDLE)
                last_nxt = (state_nxt == OWN1);
            hold_nxt  = '0;
            scan_nxt  = '0;
            slot_nxt  = 1'b0;
            frame_nxt = (state_nxt == OWN1) ? bus.data1 : bus.data0;
        end else begin
            if (hold < HOLD_LAST)
                hold_nxt = hold + HW'(1);
            if (scan == SCAN_LAST) begin
                scan_nxt = '0;
                slot_nxt = ~slot;
                // High slot ending: a new frame starts on the low digit.
                if (slot)
                    frame_nxt = (state == OWN1) ? bus.data1 : bus.data0;
            end else begin
                scan_nxt = scan + SW'(1);
            end
        end
    end

    always_comb begin
        gnt_nxt = {state_nxt == OWN1, state_nxt == OWN0};
        nib     = slot_nxt ? frame_nxt[7:4] : frame_nxt[3:0];
        seg_nxt = (state_nxt == IDLE) ? 8'h00 : hex(nib);
        if (state_nxt == IDLE || scan_nxt < BLANK_END)
            cath_nxt = 2'b00;
        else
            cath_nxt = slot_nxt ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            last           <= 1'b1;
            hold           <= '0;
            scan           <= '0;
            slot           <= 1'b0;
            frame          <= 8'h00;
            bus.gnt        <= 2'b00;
            bus.digit_seg  <= 8'h00;
            bus.digit_cath <= 2'b00;
        end else begin
            state          <= state_nxt;
            last           <= last_nxt;
            hold           <= hold_nxt;
            scan           <= scan_nxt;
            slot           <= slot_nxt;
            frame          <= frame_nxt;
            bus.gnt        <= gnt_nxt;
            bus.digit_seg  <= seg_nxt;
            bus.digit_cath <= cath_nxt;
        end
    end
endmodule

// File: tb/tb_disp_share_sched.sv
// Scoreboard bench: a cycle-level reference model queues the
// expected outputs, a monitor compares them after each edge.
module tb_disp_share_sched;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int HC = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    disp_share_sched_if bus ();

    disp_share_sched #(
        .SCAN_DIV (SD),
        .BLANK_CYC(BL),
        .HOLD_CYC (HC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] hex_tab [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    logic [11:0] q [$];

    // Model state: owner -1 = idle, t = cycles since grant change.
    int owner, last, hold, t;
    logic [7:0] frame;

    task automatic chk(
        input string nm,
        input logic [11:0] act,
        input logic [11:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h",
                     nm, cyc_n, act, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return (last == 0) ? 1 : 0;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    function automatic logic [11:0] expect_now();
        logic [1:0] g, c;
        logic [7:0] s;
        int pos, hi;
        if (owner < 0) return 12'h000;
        g = (owner == 1) ? 2'b10 : 2'b01;
        pos = t % SD;
        hi = (t / SD) % 2;
        if (pos < BL) c = 2'b00;
        else c = hi ? 2'b10 : 2'b01;
        s = hex_tab[hi ? frame[7:4] : frame[3:0]];
        return {g, c, s};
    endfunction

    task automatic model_reset();
        owner = -1;
        last = 1;
        hold = 0;
        t = 0;
        frame = 8'h00;
    endtask

    task automatic model_step(
        input logic [1:0] r,
        input logic [7:0] d0,
        input logic [7:0] d1
    );
        int nxt;
        if (owner < 0 || !r[owner]) nxt = pick(r);
        else if (hold >= HC - 1 && r[1 - owner]) nxt = 1 - owner;
        else nxt = owner;
        if (nxt != owner) begin
            owner = nxt;
            if (nxt >= 0) last = nxt;
            hold = 0;
            t = 0;
            frame = (nxt == 1) ? d1 : d0;
        end else begin
            hold++;
            t++;
            if (owner >= 0 && t % (2 * SD) == 0)
                frame = (owner == 1) ? d1 : d0;
        end
        q.push_back(expect_now());
    endtask

    task automatic cyc(
        input logic [1:0] r,
        input logic [7:0] d0,
        input logic [7:0] d1
    );
        @(negedge clk);
        rst = 1'b1;
        bus.req = r;
        bus.data0 = d0;
        bus.data1 = d1;
        model_step(r, d0, d1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async",
            {bus.gnt, bus.digit_cath, bus.digit_seg}, 12'h000);
        model_reset();
        q.push_back(12'h000);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            q.push_back(12'h000);
        end
    endtask

    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(posedge clk);
            cyc_n++;
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out", {bus.gnt, bus.digit_cath, bus.digit_seg}, e);
            end
        end
    end

    initial begin : driver
        logic [1:0] r;
        logic [7:0] d0, d1;
        bus.req = 2'b00;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        model_reset();
        do_reset(3);
        repeat (4) cyc(2'b00, 8'h00, 8'h00);
        // single source, then a mid-frame data change
        repeat (27) cyc(2'b01, 8'h3A, 8'h00);
        repeat (30) cyc(2'b01, 8'h5C, 8'h00);
        repeat (2) cyc(2'b00, 8'h5C, 8'h00);
        // tie from reset, hold limit, drop and release
        do_reset(2);
        repeat (30) cyc(2'b11, 8'h12, 8'hEF);
        repeat (5) cyc(2'b01, 8'h12, 8'hEF);
        repeat (10) cyc(2'b10, 8'h12, 8'hEF);
        repeat (4) cyc(2'b00, 8'h12, 8'hEF);
        // reset landing in a high slot, then source 1 alone
        cyc(2'b01, 8'h7B, 8'h46);
        for (int i = 0; i < 2 * SD; i++) begin
            if ((t / SD) % 2 == 1 && t % SD >= BL) break;
            cyc(2'b01, 8'h7B, 8'h46);
        end
        do_reset(2);
        repeat (24) cyc(2'b10, 8'h7B, 8'h46);
        // randomized traffic
        r = 2'b00;
        d0 = 8'h00;
        d1 = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) r = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) d0 = 8'($urandom);
            if ($urandom_range(15) == 0) d1 = 8'($urandom);
            if ($urandom_range(499) == 0)
                do_reset(1 + $urandom_range(2));
            else
                cyc(r, d0, d1);
        end
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
